// File: rtl/uart_tx_byte_fifo.sv
// uart_tx_byte_fifo: byte FIFO between strobe-only terminal producers and
// the usb_uart uart_in valid/ready pipeline. First-word-fall-through read,
// strobes dropped when full (recorded in a sticky overflow flag).
module uart_tx_byte_fifo #(
    parameter int AW = 4
) (
    input  logic          clk_48mhz,
    input  logic          reset_n,
    input  logic [7:0]    wr_data,
    input  logic          wr_strobe,
    input  logic          clr_overflow,
    output logic [7:0]    uart_in_data,
    output logic          uart_in_valid,
    input  logic          uart_in_ready,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int DEPTH = 2 ** AW;

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_overflow;

    logic        w_pop;
    logic        w_push;
    logic        w_drop;

    // Status decode from registered pointers only; ready never reaches valid.
    always_comb begin
        level         = r_wr_ptr - r_rd_ptr;
        empty         = (r_wr_ptr == r_rd_ptr);
        full          = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        uart_in_valid = !empty;
        uart_in_data  = r_mem[r_rd_ptr[AW-1:0]];
        overflow      = r_overflow;
        // A pop at the same edge frees the slot, so a full FIFO still accepts.
        w_pop         = uart_in_valid && uart_in_ready;
        w_push        = wr_strobe && (!full || w_pop);
        w_drop        = wr_strobe && full && !w_pop;
    end

    // Storage array; not cleared by reset, writes suppressed during reset.
    always_ff @(posedge clk_48mhz) begin
        if (reset_n && w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    // Pointer and sticky overflow update; a drop beats a same-edge clear.
    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_overflow)
                r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_byte_fifo.sv
// Directed bench for uart_tx_byte_fifo (AW=4, DEPTH=16).
module tb_uart_tx_byte_fifo;

    localparam int AW = 4;

    logic          clk_48mhz = 1'b0;
    logic          reset_n;
    logic [7:0]    wr_data;
    logic          wr_strobe;
    logic          clr_overflow;
    logic [7:0]    uart_in_data;
    logic          uart_in_valid;
    logic          uart_in_ready;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_byte_fifo #(.AW(AW)) dut (
        .clk_48mhz     (clk_48mhz),
        .reset_n       (reset_n),
        .wr_data       (wr_data),
        .wr_strobe     (wr_strobe),
        .clr_overflow  (clr_overflow),
        .uart_in_data  (uart_in_data),
        .uart_in_valid (uart_in_valid),
        .uart_in_ready (uart_in_ready),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_data   = d;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    logic [7:0] q[$];
    int popped;
    int cyc;
    int pushed;
    logic [7:0] exp_b;

    initial begin
        reset_n = 1'b0; wr_data = '0; wr_strobe = 1'b0;
        clr_overflow = 1'b0; uart_in_ready = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", uart_in_valid, 0);
        check("rst_ovf", overflow, 0);

        // 1: single byte latency and pop
        push(8'h41);
        check("t1_valid", uart_in_valid, 1);
        check("t1_data", uart_in_data, 8'h41);
        check("t1_level", level, 1);
        uart_in_ready = 1'b1;
        tick();
        uart_in_ready = 1'b0;
        check("t1_empty", empty, 1);
        check("t1_level0", level, 0);

        // 2: fill to full, then drop 0xAA
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t2_full", full, 1);
        check("t2_level", level, 16);
        check("t2_ovf0", overflow, 0);
        push(8'hAA);
        check("t2_ovf1", overflow, 1);
        check("t2_level_drop", level, 16);

        // 5: clear coinciding with a drop keeps the flag, clear alone clears it
        clr_overflow = 1'b1;
        push(8'hBB);
        clr_overflow = 1'b0;
        check("t5_set_wins", overflow, 1);
        check("t5_level", level, 16);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t5_cleared", overflow, 0);

        // 3: push+pop on a full FIFO is accepted
        uart_in_ready = 1'b1;
        push(8'h55);
        uart_in_ready = 1'b0;
        check("t3_level", level, 16);
        check("t3_ovf", overflow, 0);
        check("t3_full", full, 1);

        // Drain: 0x01..0x0F then 0x55; 0xAA/0xBB never appear
        uart_in_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            exp_b = (i == 16) ? 8'h55 : 8'(i);
            check("drain_valid", uart_in_valid, 1);
            check("drain_data", uart_in_data, exp_b);
            tick();
        end
        uart_in_ready = 1'b0;
        check("drain_empty", empty, 1);

        // 4: wrap with random ready against a queue model
        popped = 0; pushed = 0; cyc = 0;
        while (popped < 40 && cyc < 1000) begin
            wr_strobe     = (pushed < 40) && (q.size() < 16) && ($urandom_range(0, 3) != 0);
            wr_data       = 8'(pushed * 7 + 3);
            uart_in_ready = 1'($urandom_range(0, 1));
            check("t4_level", level, q.size());
            check("t4_valid", uart_in_valid, (q.size() != 0));
            if (uart_in_valid && uart_in_ready && q.size() != 0) begin
                check("t4_data", uart_in_data, q.pop_front());
                popped++;
            end
            if (wr_strobe) begin
                q.push_back(wr_data);
                pushed++;
            end
            tick();
            cyc++;
        end
        wr_strobe = 1'b0; uart_in_ready = 1'b0;
        check("t4_done", popped, 40);
        check("t4_empty", empty, 1);

        // 6: reset with 5 queued bytes and a strobe in the reset cycle
        for (int i = 0; i < 5; i++) push(8'(8'h90 + i));
        check("t6_level5", level, 5);
        reset_n = 1'b0;
        push(8'h99);
        reset_n = 1'b1;
        check("t6_valid", uart_in_valid, 0);
        check("t6_level", level, 0);
        check("t6_ovf", overflow, 0);
        push(8'h7E);
        check("t6_first_valid", uart_in_valid, 1);
        check("t6_first_data", uart_in_data, 8'h7E);
        check("t6_first_level", level, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
